// File: rtl/timing_pkg.sv
// timing_pkg
//   Shared definitions for the timer peripheral register front end:
//   register byte offsets, field bit positions, bus FSM state encoding and
//   the decoded-access record produced by the register decoder.
package timing_pkg;

  // Register byte offsets (word aligned)
  localparam logic [31:0] OFF_CTRL = 32'h0000_0000;
  localparam logic [31:0] OFF_CMD  = 32'h0000_0004;
  localparam logic [31:0] OFF_TERM = 32'h0000_0008;
  localparam logic [31:0] OFF_STAT = 32'h0000_000C;
  localparam logic [31:0] OFF_CNT  = 32'h0000_0010;

  // Field bit positions
  localparam int CTRL_MODE_BIT = 0;
  localparam int CTRL_IE_BIT   = 1;
  localparam int CMD_START_BIT = 0;
  localparam int CMD_HALT_BIT  = 1;
  localparam int STAT_RUN_BIT  = 0;
  localparam int STAT_PEND_BIT = 1;

  // Bus FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  // Result of decoding one bus access against the current register state
  typedef struct packed {
    logic        err;
    logic        wr_ctrl;
    logic        wr_term;
    logic        wr_cmd;
    logic        clr_pend;
    logic [31:0] rdata;
  } access_t;

endpackage

// File: rtl/timing_pulse_edge.sv
// timing_pulse_edge
//   Rising-edge detector. The previous input level is registered and the
//   rise output is high during any cycle where din is 1 and was 0 on the
//   previous clock edge.
// Ports
//   clk    in  clock
//   reset  in  synchronous active-high reset (history cleared to 0)
//   din    in  level/pulse input
//   rise   out 1 while din=1 and previous sample was 0
module timing_pulse_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_prev;

  always_ff @(posedge clk) begin
    if (reset) din_prev <= 1'b0;
    else       din_prev <= din;
  end

  assign rise = din & ~din_prev;

endmodule

// File: rtl/timing_regs.sv
// timing_regs
//   Bus-side register front end of the timer peripheral. Accepts single-beat
//   valid/ready accesses, decodes them into CTRL/CMD/TERMCOUNT/STATUS/CURRCOUNT,
//   drives the timer controls and turns CMD writes into 1-cycle triggers.
//   Rising edges of rf_int set a sticky write-1-to-clear pending bit.
// Ports
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_ready    request handshake; req_we, req_addr, req_wdata
//   rsp_valid/rsp_ready    response handshake; rsp_rdata, rsp_err
//   ro_trig_start/halt     1-cycle trigger pulses to the timer
//   ro_mode, ro_termcount  timer configuration
//   rf_status, rf_currcount, rf_int   timer results
//   irq                    PEND & IE
module timing_regs
  import timing_pkg::*;
#(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] TERM_RST = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ro_trig_start,
  output logic              ro_trig_halt,
  output logic              ro_mode,
  output logic [31:0]       ro_termcount,
  input  logic              rf_status,
  input  logic [31:0]       rf_currcount,
  input  logic              rf_int,
  output logic              irq
);

  logic [0:0]  state;
  logic        accept;
  logic        ie;
  logic        pend;
  logic        int_rise;
  logic [31:0] byte_addr;
  access_t     acc;

  timing_pulse_edge u_int_edge (
    .clk   (clk),
    .reset (reset),
    .din   (rf_int),
    .rise  (int_rise)
  );

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid & req_ready;
  assign irq       = pend & ie;

  // Byte offset with the sub-word bits dropped, widened for the decode compare
  assign byte_addr = {{(32 - ADDR_W){1'b0}}, req_addr[ADDR_W-1:2], 2'b00};

  // Decode the presented access: read data, error, and which register
  // updates it would cause. Configuration writes are refused while the
  // timer runs so the counter never sees its setup change under it.
  always_comb begin
    acc = '0;
    case (byte_addr)
      OFF_CTRL: begin
        if (!req_we) begin
          acc.rdata[CTRL_MODE_BIT] = ro_mode;
          acc.rdata[CTRL_IE_BIT]   = ie;
        end else if (rf_status) begin
          acc.err = 1'b1;
        end else begin
          acc.wr_ctrl = 1'b1;
        end
      end
      OFF_CMD: begin
        if (req_we) acc.wr_cmd = 1'b1;
      end
      OFF_TERM: begin
        if (!req_we)        acc.rdata   = ro_termcount;
        else if (rf_status) acc.err     = 1'b1;
        else                acc.wr_term = 1'b1;
      end
      OFF_STAT: begin
        if (!req_we) begin
          acc.rdata[STAT_RUN_BIT]  = rf_status;
          acc.rdata[STAT_PEND_BIT] = pend;
        end else begin
          acc.clr_pend = req_wdata[STAT_PEND_BIT];
        end
      end
      OFF_CNT: begin
        if (!req_we) acc.rdata = rf_currcount;
        else         acc.err   = 1'b1;
      end
      default: acc.err = 1'b1;
    endcase
  end

  // Bus FSM: one outstanding access, response held until consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp_rdata <= acc.rdata;
            rsp_err   <= acc.err;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register updates and trigger pulses; triggers default low so each
  // CMD write yields exactly one cycle of pulse. HALT takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      ro_mode       <= 1'b0;
      ie            <= 1'b0;
      ro_termcount  <= TERM_RST;
      ro_trig_start <= 1'b0;
      ro_trig_halt  <= 1'b0;
    end else begin
      ro_trig_start <= 1'b0;
      ro_trig_halt  <= 1'b0;
      if (accept && acc.wr_ctrl) begin
        ro_mode <= req_wdata[CTRL_MODE_BIT];
        ie      <= req_wdata[CTRL_IE_BIT];
      end
      if (accept && acc.wr_term) ro_termcount <= req_wdata;
      if (accept && acc.wr_cmd) begin
        ro_trig_halt  <= req_wdata[CMD_HALT_BIT];
        ro_trig_start <= req_wdata[CMD_START_BIT] & ~req_wdata[CMD_HALT_BIT];
      end
    end
  end

  // Sticky pending bit: a new edge beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) pend <= 1'b0;
    else       pend <= int_rise | (pend & ~(accept & acc.clr_pend));
  end

endmodule

// File: tb/tb_timing_regs.sv
// tb_timing_regs
//   Self-checking bench for timing_regs: a behavioural register-map model
//   is compared with the DUT on every falling edge, plus directed literal
//   checks, followed by randomized bus traffic and timer inputs.
module tb_timing_regs;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ro_trig_start;
  logic        ro_trig_halt;
  logic        ro_mode;
  logic [31:0] ro_termcount;
  logic        rf_status;
  logic [31:0] rf_currcount;
  logic        rf_int;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int start_count = 0;
  int halt_count  = 0;
  logic check_en = 1'b0;
  logic rand_rf  = 1'b0;

  // Model state: the register file as the software would see it
  logic        m_busy, m_err, m_mode, m_ie, m_pend, m_int_d, m_start, m_halt, m_clr;
  logic [31:0] m_rdata, m_term;

  timing_regs #(.ADDR_W(5), .TERM_RST(32'hFFFF_FFFF)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .ro_trig_start (ro_trig_start),
    .ro_trig_halt  (ro_trig_halt),
    .ro_mode       (ro_mode),
    .ro_termcount  (ro_termcount),
    .rf_status     (rf_status),
    .rf_currcount  (rf_currcount),
    .rf_int        (rf_int),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report a mismatch
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one accepted access, computed from the register map rules
  function automatic void model_access();
    int word;
    word    = int'(req_addr) / 4;
    m_rdata = 32'd0;
    m_err   = 1'b0;
    if (word > 4) begin
      m_err = 1'b1;
    end else if (!req_we) begin
      if (word == 0) m_rdata = 32'(m_ie) * 2 + 32'(m_mode);
      if (word == 2) m_rdata = m_term;
      if (word == 3) m_rdata = 32'(m_pend) * 2 + 32'(rf_status);
      if (word == 4) m_rdata = rf_currcount;
    end else begin
      if (word == 0) begin
        if (rf_status) m_err = 1'b1;
        else begin m_mode = req_wdata[0]; m_ie = req_wdata[1]; end
      end
      if (word == 1) begin
        if (req_wdata[1])      m_halt  = 1'b1;
        else if (req_wdata[0]) m_start = 1'b1;
      end
      if (word == 2) begin
        if (rf_status) m_err = 1'b1;
        else           m_term = req_wdata;
      end
      if (word == 3) m_clr = req_wdata[1];
      if (word == 4) m_err = 1'b1;
    end
  endfunction

  // Model advances on every rising edge from the inputs the bench drives
  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_err = 0; m_rdata = 0; m_mode = 0; m_ie = 0; m_pend = 0;
      m_int_d = 0; m_start = 0; m_halt = 0; m_term = 32'hFFFF_FFFF;
    end else begin
      m_start = 0;
      m_halt  = 0;
      m_clr   = 0;
      if (m_busy) begin
        if (rsp_ready) m_busy = 0;
      end else if (req_valid) begin
        model_access();
        m_busy = 1;
      end
      m_pend  = (rf_int && !m_int_d) || (m_pend && !m_clr);
      m_int_d = rf_int;
    end
  end

  // Every falling edge, compare all outputs against the model
  always @(negedge clk) begin
    if (ro_trig_start) start_count++;
    if (ro_trig_halt)  halt_count++;
    if (check_en) begin
      check_output("req_ready", 32'(req_ready), 32'(!m_busy));
      check_output("rsp_valid", 32'(rsp_valid), 32'(m_busy));
      if (m_busy) begin
        check_output("rsp_rdata", rsp_rdata, m_rdata);
        check_output("rsp_err", 32'(rsp_err), 32'(m_err));
      end
      check_output("trig_start", 32'(ro_trig_start), 32'(m_start));
      check_output("trig_halt", 32'(ro_trig_halt), 32'(m_halt));
      check_output("ro_mode", 32'(ro_mode), 32'(m_mode));
      check_output("ro_termcount", ro_termcount, m_term);
      check_output("irq", 32'(irq), 32'(m_pend && m_ie));
    end
  end

  // Advance one cycle; timer inputs wander randomly when enabled
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rf) begin
      rf_status    = ($urandom_range(0, 3) == 0);
      rf_int       = ($urandom_range(0, 2) == 0);
      rf_currcount = $urandom;
    end
  endtask

  // One complete bus access; rsp_ready is withheld for 'hold' cycles
  task automatic apply_stimulus(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                                input int hold, input logic int_with_req,
                                output logic [31:0] rdata, output logic err);
    tick();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'b0;
    if (int_with_req) rf_int = 1'b1;
    tick();
    req_valid = 1'b0;
    if (int_with_req) rf_int = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (rand_rf) begin
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 5'($urandom);
        req_wdata = $urandom;
      end
      tick();
    end
    rdata     = rsp_rdata;
    err       = rsp_err;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          s0, h0;

  initial begin
    reset = 1'b1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    rsp_ready = 0; rf_status = 0; rf_currcount = 0; rf_int = 0;
    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b1;
    reset    = 1'b0;

    // Reset values
    check_output("rst_irq", 32'(irq), 32'd0);
    check_output("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_output("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_output("rst_req_ready", 32'(req_ready), 32'd1);
    check_output("rst_termcount", ro_termcount, 32'hFFFF_FFFF);
    apply_stimulus(1'b0, 5'h08, 32'd0, 0, 1'b0, rd, er);
    check_output("rd_term_rst", rd, 32'hFFFF_FFFF);
    check_output("rd_term_err", 32'(er), 32'd0);
    apply_stimulus(1'b0, 5'h00, 32'd0, 0, 1'b0, rd, er);
    check_output("rd_ctrl_rst", rd, 32'd0);

    // Configure and start
    apply_stimulus(1'b1, 5'h08, 32'd100, 0, 1'b0, rd, er);
    apply_stimulus(1'b1, 5'h00, 32'd3, 0, 1'b0, rd, er);
    s0 = start_count; h0 = halt_count;
    apply_stimulus(1'b1, 5'h04, 32'd1, 0, 1'b0, rd, er);
    check_output("start_pulses", 32'(start_count - s0), 32'd1);
    check_output("start_no_halt", 32'(halt_count - h0), 32'd0);
    check_output("termcount_100", ro_termcount, 32'd100);
    check_output("mode_1", 32'(ro_mode), 32'd1);

    // Interrupt pulse sets PEND, W1C clears it
    rf_currcount = 32'h0000_1234;
    tick(); rf_int = 1'b1;
    tick(); rf_int = 1'b0; rf_status = 1'b1;
    tick();
    apply_stimulus(1'b0, 5'h0C, 32'd0, 0, 1'b0, rd, er);
    check_output("stat_pend_run", rd, 32'h3);
    check_output("irq_set", 32'(irq), 32'd1);
    apply_stimulus(1'b1, 5'h0C, 32'd2, 0, 1'b0, rd, er);
    check_output("w1c_err", 32'(er), 32'd0);
    check_output("irq_cleared", 32'(irq), 32'd0);

    // New edge in the same cycle as the clear: set wins
    tick(); rf_int = 1'b1;
    tick(); rf_int = 1'b0;
    tick();
    apply_stimulus(1'b1, 5'h0C, 32'd2, 0, 1'b1, rd, er);
    check_output("irq_set_wins", 32'(irq), 32'd1);
    apply_stimulus(1'b0, 5'h0C, 32'd0, 0, 1'b0, rd, er);
    check_output("stat_set_wins", rd, 32'h3);

    // Errors while running and on bad offsets
    apply_stimulus(1'b1, 5'h08, 32'd5, 0, 1'b0, rd, er);
    check_output("term_run_err", 32'(er), 32'd1);
    check_output("term_unchanged", ro_termcount, 32'd100);
    apply_stimulus(1'b1, 5'h14, 32'd0, 0, 1'b0, rd, er);
    check_output("unmapped_err", 32'(er), 32'd1);
    apply_stimulus(1'b0, 5'h10, 32'd0, 0, 1'b0, rd, er);
    check_output("rd_currcount", rd, 32'h0000_1234);

    // START+HALT: only HALT, with a stalled response
    s0 = start_count; h0 = halt_count;
    apply_stimulus(1'b1, 5'h04, 32'd3, 3, 1'b0, rd, er);
    check_output("halt_pulses", 32'(halt_count - h0), 32'd1);
    check_output("halt_no_start", 32'(start_count - s0), 32'd0);
    check_output("cmd3_err", 32'(er), 32'd0);

    // Reset coinciding with a CMD accept: no pulse, no response
    tick();
    s0 = start_count;
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h04; req_wdata = 32'd1;
    tick();
    reset = 1'b0; req_valid = 1'b0;
    tick();
    check_output("rst_no_start", 32'(start_count - s0), 32'd0);
    check_output("rst_no_rsp", 32'(rsp_valid), 32'd0);

    // Reset during an outstanding response drops it
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h08;
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("rst_drop_rsp", 32'(rsp_valid), 32'd0);
    check_output("rst_drop_ready", 32'(req_ready), 32'd1);

    // Randomized traffic against the model
    rf_status = 1'b0;
    rand_rf   = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) tick();
      apply_stimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom,
                     $urandom_range(0, 2), 1'b0, rd, er);
    end
    rand_rf = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
